trig_pulse_gen: RTL and testbench

- Output-side counterpart of the button conditioning path: converts a single-cycle event request into one clean, fixed-width, rate-limited output pulse.
- Primary use is the HC-SR04 TRIG pin. A debounced button pulse or a periodic measurement scheduler drives i_start; o_trig goes to the sensor.
- Enforces the minimum repetition period, so the echo receiver never sees overlapping measurements.

---
 rtl/trig_pulse_gen.sv | 132 +++++++++++++
 tb/tb_trig_pulse_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/trig_pulse_gen.sv
// trig_pulse_gen: turns a start request into one fixed-width trigger pulse.
// After the pulse falls, a hold-off window follows, which limits the repetition rate.
// Typical load is the HC-SR04 TRIG pin, so echo measurements never overlap.
// Every duration is an exact multiple of the internal tick period. The
// prescaler and tick counter restart on every state entry, so there is no
// free-running phase error.
module trig_pulse_gen #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int TICK_HZ    = 1_000_000,
    parameter int TRIG_US    = 10,
    parameter int HOLDOFF_US = 60_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_trig,
    output logic o_busy,
    output logic o_done,
    output logic o_drop
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int T_MAX    = (TRIG_US > HOLDOFF_US) ? TRIG_US : HOLDOFF_US;
    localparam int TW       = $clog2(T_MAX + 1);

    // Terminal counts. Every count runs from zero, so no counter can overflow.
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TRIG_LAST  = TW'(TRIG_US - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLDOFF_US - 1);

    // Reject illegal parameter sets at elaboration rather than in silicon.
    if (CLK_FREQ % TICK_HZ != 0) begin : g_chk_div_int
        $error("trig_pulse_gen: CLK_FREQ must be an integer multiple of TICK_HZ");
    end
    if (TICK_DIV < 2) begin : g_chk_div_min
        $error("trig_pulse_gen: CLK_FREQ/TICK_HZ must be at least 2");
    end
    if (TRIG_US < 1 || HOLDOFF_US < 1) begin : g_chk_durations
        $error("trig_pulse_gen: TRIG_US and HOLDOFF_US must be at least 1");
    end

    // Binary 2-bit encoding. The fourth code (2'b11) is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_TRIG = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [TW-1:0] tcnt;
    logic          tick;

    // Tick strobe: high on the cycle in which the prescaler wraps.
    assign tick = (presc == PRESC_LAST);

    // Single FSM process. It owns the time base and drives every registered output.
    // NOTE: asynchronous reset clears state and outputs immediately on assertion,
    // so o_trig drops without waiting for a clock edge; all state uses non-blocking
    // assignments so every branch reads the pre-edge values consistently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            presc  <= '0;
            tcnt   <= '0;
            o_trig <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            // Default the two status strobes low so that each lasts exactly one cycle.
            o_done <= 1'b0;
            o_drop <= 1'b0;

            case (state)
                S_IDLE: begin
                    presc <= '0;
                    tcnt  <= '0;
                    if (i_start) begin
                        state  <= S_TRIG;
                        o_trig <= 1'b1;
                        o_busy <= 1'b1;
                    end
                end

                S_TRIG: begin
                    // Requests while busy are dropped and flagged, never queued.
                    o_drop <= i_start;
                    if (tick) begin
                        presc <= '0;
                        if (tcnt == TRIG_LAST) begin
                            state  <= S_HOLD;
                            tcnt   <= '0;
                            o_trig <= 1'b0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end

                S_HOLD: begin
                    o_drop <= i_start;
                    if (tick) begin
                        presc <= '0;
                        if (tcnt == HOLD_LAST) begin
                            state  <= S_IDLE;
                            tcnt   <= '0;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    presc  <= '0;
                    tcnt   <= '0;
                    o_trig <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_pulse_gen.sv
// tb_trig_pulse_gen: directed and randomized checks of trig_pulse_gen.
// The bench uses TICK_DIV=4, TRIG_US=10 and HOLDOFF_US=20.
// The reference model counts down the remaining busy cycles of the current
// measurement. It does not model the prescaler or the tick counter.
module tb_trig_pulse_gen;

    localparam int CLK_FREQ   = 4_000_000;
    localparam int TICK_HZ    = 1_000_000;
    localparam int TRIG_US    = 10;
    localparam int HOLDOFF_US = 20;
    localparam int DIV        = CLK_FREQ / TICK_HZ;
    localparam int TRIG_CYC   = TRIG_US * DIV;        // 40
    localparam int HOLD_CYC   = HOLDOFF_US * DIV;     // 80
    localparam int BUSY_CYC   = TRIG_CYC + HOLD_CYC;  // 120

    logic clk;
    logic rst;
    logic i_start;
    logic o_trig;
    logic o_busy;
    logic o_done;
    logic o_drop;

    int n_assert;
    int n_fail;
    int cyc;

    // Reference model state: the number of busy cycles left, plus the expected strobes.
    int rem;
    bit m_done;
    bit m_drop;

    // Rising-edge bookkeeping used by the level-held scenario.
    logic trig_q;
    int   last_rise;
    int   n_rise;

    trig_pulse_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .TICK_HZ   (TICK_HZ),
        .TRIG_US   (TRIG_US),
        .HOLDOFF_US(HOLDOFF_US)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_start(i_start),
        .o_trig (o_trig),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_drop (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Model one clock edge. A measurement lasts BUSY_CYC cycles from acceptance.
    // The trigger is high for the first TRIG_CYC of them. Requests during a
    // measurement are only flagged.
    task automatic model_edge(input logic s);
        m_done = 1'b0;
        m_drop = 1'b0;
        if (rem == 0) begin
            if (s) rem = BUSY_CYC;
        end else begin
            m_drop = s;
            rem--;
            if (rem == 0) m_done = 1'b1;
        end
    endtask

    task automatic check_all();
        check("trig", o_trig, rem > HOLD_CYC);
        check("busy", o_busy, rem > 0);
        check("done", o_done, m_done);
        check("drop", o_drop, m_drop);
    endtask

    // Drive i_start away from the edge, model the edge, then sample 1 time unit later.
    task automatic step(input logic s);
        @(negedge clk);
        i_start = s;
        @(posedge clk);
        cyc++;
        model_edge(s);
        #1;
        if (o_trig && !trig_q) begin
            last_rise = cyc;
            n_rise++;
        end
        trig_q = o_trig;
        check_all();
    endtask

    task automatic steps(input int n, input logic s);
        for (int i = 0; i < n; i++) step(s);
    endtask

    // Assert reset between edges and confirm that the outputs clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        i_start = 1'b0;
        #1;
        rem    = 0;
        m_done = 1'b0;
        m_drop = 1'b0;
        trig_q = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        rem       = 0;
        m_done    = 1'b0;
        m_drop    = 1'b0;
        trig_q    = 1'b0;
        last_rise = 0;
        n_rise    = 0;
        i_start   = 1'b0;
        rst       = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        do_reset();
        steps(3, 1'b0);

        // A single 1-cycle request: trig is high 40 cycles, busy 120, done pulses once.
        step(1'b1);
        steps(130, 1'b0);

        // Requests inside TRIG (+5) and inside HOLD (+60) are dropped, not queued.
        step(1'b1);
        steps(4, 1'b0);
        step(1'b1);
        steps(54, 1'b0);
        step(1'b1);
        steps(70, 1'b0);

        // Level-held request: the rising edges of trig are 121 cycles apart.
        n_rise = 0;
        for (int i = 0; i < 300; i++) begin
            int prev;
            prev = last_rise;
            step(1'b1);
            if (n_rise >= 2 && last_rise == cyc) check_int("period", last_rise - prev, BUSY_CYC + 1);
        end
        check_int("rises", n_rise, 3);
        steps(130, 1'b0);

        // A request on the cycle done is high is accepted at once, with no drop.
        step(1'b1);
        steps(BUSY_CYC, 1'b0);
        check("done_seen", o_done, 1'b1);
        step(1'b1);
        check("rearm_trig", o_trig, 1'b1);
        check("rearm_nodrop", o_drop, 1'b0);
        steps(130, 1'b0);

        // Reset asserted 15 cycles into TRIG, then a full pulse after release.
        step(1'b1);
        steps(15, 1'b0);
        check("pre_rst_trig", o_trig, 1'b1);
        do_reset();
        steps(2, 1'b0);
        step(1'b1);
        steps(130, 1'b0);

        // Randomized requests: sparse pulses mixed with occasional held bursts.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) steps($urandom_range(1, 150), 1'b1);
            else step($urandom_range(0, 15) == 0);
        end
        steps(130, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
